triangle_assemble: RTL and testbench

TRIANGLE_ASSEMBLE -- requirements
Module: triangle_assemble

---
 rtl/triangle_assemble.sv | 151 +++++++++++++++
 tb/tb_triangle_assemble.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/triangle_assemble.sv
// triangle_assemble: gathers clipped vertices into triangles, culls
// degenerate ones and queues good ones in a small first-word-fall-through
// FIFO for the rasterizer. Lost triangles raise a sticky overflow flag.
module triangle_assemble #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  input  logic [3:0][31:0]        vertex_in,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic [2:0][3:0][31:0]   triangle_out,
  output logic                    overflow_out,
  output logic [CNT_W-1:0]        dropped_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef logic [3:0][31:0]      vtx_t;
  typedef logic [2:0][3:0][31:0] tri_vec_t;

  // A vertex with a negative or zero w cannot be rasterized.
  function automatic logic w_bad(input vtx_t v);
    return v[3][31] | (v[3][30:0] == 31'd0);
  endfunction

  // Degenerate: any unusable w, or two vertices sharing the same position.
  function automatic logic is_degenerate(input tri_vec_t t);
    return w_bad(t[0]) | w_bad(t[1]) | w_bad(t[2]) |
           (t[0] == t[1]) | (t[0] == t[2]) | (t[1] == t[2]);
  endfunction

  logic [1:0]             idx_q, idx_d;
  vtx_t                   slot0_q, slot0_d, slot1_q, slot1_d;
  tri_vec_t [DEPTH-1:0]   mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  tri_vec_t               head_q, head_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       dropped_q, dropped_d;

  tri_vec_t               new_tri_s;
  logic                   complete_s, degen_s, full_s, pop_s, push_s, lost_s;

  // Next-state: vertex gathering, culling, FIFO push/pop and head refresh.
  always_comb begin
    idx_d      = idx_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    dropped_d  = dropped_q;

    new_tri_s  = {vertex_in, slot1_q, slot0_q};
    complete_s = valid_in && (idx_q == 2'd2);
    degen_s    = is_degenerate(new_tri_s);
    full_s     = (count_q == FULL_CNT);
    pop_s      = valid_q && ready_in;
    push_s     = complete_s && !degen_s && (!full_s || pop_s);
    lost_s     = complete_s && !degen_s && full_s && !pop_s;

    if (valid_in) begin
      case (idx_q)
        2'd0:    slot0_d = vertex_in;
        2'd1:    slot1_d = vertex_in;
        default: slot0_d = slot0_q;
      endcase
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end

    if (complete_s && degen_s && (dropped_q != {CNT_W{1'b1}})) begin
      dropped_d = dropped_q + CNT_W'(1);
    end else begin
      dropped_d = dropped_q;
    end

    if (lost_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    // When full with a pop, the write slot is the one being vacated.
    if (push_s) begin
      mem_d[wr_ptr_q] = new_tri_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    head_d  = mem_d[rd_ptr_d];
    valid_d = (count_d != CW'(0));
  end

  // State registers; reset clears everything including slots and FIFO storage.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q     <= 2'd0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      dropped_q <= '0;
    end else begin
      idx_q     <= idx_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      dropped_q <= dropped_d;
    end
  end

  assign valid_out    = valid_q;
  assign triangle_out = head_q;
  assign overflow_out = ovf_q;
  assign dropped_out  = dropped_q;

endmodule

// File: tb/tb_triangle_assemble.sv
// Bench for triangle_assemble: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_triangle_assemble;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                  clk_in = 1'b0;
  logic                  rst_in = 1'b0;
  logic                  valid_in = 1'b0;
  logic [3:0][31:0]      vertex_in = '0;
  logic                  ready_in = 1'b0;
  logic                  valid_out;
  logic [2:0][3:0][31:0] triangle_out;
  logic                  overflow_out;
  logic [CNT_W-1:0]      dropped_out;

  triangle_assemble #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .vertex_in(vertex_in),
    .ready_in(ready_in), .valid_out(valid_out), .triangle_out(triangle_out),
    .overflow_out(overflow_out), .dropped_out(dropped_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [127:0] part_q[$];
  logic [383:0] fifo_q[$];
  logic         m_ovf;
  int           m_drop;

  logic [127:0] va, vb, vc, vcn;

  task automatic check_val(input string tag, input logic [383:0] got, input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit degen(input logic [383:0] t);
    logic [127:0] v[3];
    logic [31:0]  w;
    for (int i = 0; i < 3; i++) begin
      v[i] = t[i*128 +: 128];
      w = v[i][127:96];
      if (w[31] == 1'b1 || w[30:0] == 31'd0) return 1'b1;
    end
    return (v[0] == v[1]) || (v[0] == v[2]) || (v[1] == v[2]);
  endfunction

  task automatic model_clear();
    part_q.delete();
    fifo_q.delete();
    m_ovf = 1'b0;
    m_drop = 0;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_valid"}, 384'(valid_out), 384'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) check_val({tag, "_tri"}, triangle_out, fifo_q[0]);
    check_val({tag, "_ovf"}, 384'(overflow_out), 384'(m_ovf));
    check_val({tag, "_drop"}, 384'(dropped_out), 384'(m_drop));
  endtask

  // one clock: drive, advance the model, then sample after the edge
  task automatic step(input logic vin, input logic [127:0] v, input logic rdy, input string tag);
    logic [383:0] t;
    bit pop;
    valid_in = vin;
    vertex_in = v;
    ready_in = rdy;
    pop = (fifo_q.size() != 0) && rdy;
    if (pop) void'(fifo_q.pop_front());
    if (vin) begin
      if (part_q.size() == 2) begin
        t = {v, part_q[1], part_q[0]};
        part_q.delete();
        if (degen(t)) begin
          if (m_drop < DROP_MAX) m_drop++;
        end else if (fifo_q.size() < DEPTH) begin
          fifo_q.push_back(t);
        end else begin
          m_ovf = 1'b1;
        end
      end else begin
        part_q.push_back(v);
      end
    end
    @(posedge clk_in);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 128'd0, rdy, tag);
  endtask

  task automatic do_reset(input string tag);
    valid_in = 1'b0;
    rst_in = 1'b0;
    #1;
    model_clear();
    check_val({tag, "_rst_valid"}, 384'(valid_out), 384'd0);
    check_val({tag, "_rst_tri"}, triangle_out, 384'd0);
    check_val({tag, "_rst_ovf"}, 384'(overflow_out), 384'd0);
    check_val({tag, "_rst_drop"}, 384'(dropped_out), 384'd0);
    @(posedge clk_in);
    #1;
    check_val({tag, "_rst_hold"}, 384'(valid_out), 384'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  function automatic logic [127:0] pick();
    int r;
    logic [127:0] v;
    r = $urandom_range(0, 7);
    case (r)
      0: v = va;
      1: v = vb;
      2: v = vc;
      3: v = vcn;
      4: v = {32'h80000000, 32'($urandom), 32'($urandom), 32'($urandom)};
      default: v = {1'b0, 31'($urandom_range(1, 32'h7fffffff)), 32'($urandom), 32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    va  = {32'h3F800000, 32'h3F687FCC, 32'h3E5C28F6, 32'h3F25E354};
    vb  = {32'h3F800000, 32'hBDF3B646, 32'h3F7B22D1, 32'hBEFEF9DB};
    vc  = {32'h3F800000, 32'h3F7F837B, 32'hBE6147AE, 32'h3EFB7E91};
    vcn = {32'hBF800000, 32'h3F7F837B, 32'hBE6147AE, 32'h3EFB7E91};
    model_clear();
    @(negedge clk_in);
    do_reset("init");

    // good triangle, available right after the third vertex
    step(1'b1, va, 1'b1, "good_a");
    step(1'b1, vb, 1'b1, "good_b");
    step(1'b1, vc, 1'b1, "good_c");
    check_val("good_valid", 384'(valid_out), 384'd1);
    check_val("good_tri", triangle_out, {vc, vb, va});
    check_val("good_drop", 384'(dropped_out), 384'd0);
    idle(1, 1'b1, "good_drain");

    // gapped vertices
    step(1'b1, va, 1'b0, "gap_a");
    idle(1, 1'b0, "gap_i1");
    step(1'b1, vb, 1'b0, "gap_b");
    idle(3, 1'b0, "gap_i2");
    step(1'b1, vc, 1'b0, "gap_c");
    check_val("gap_tri", triangle_out, {vc, vb, va});
    idle(1, 1'b1, "gap_pop");
    check_val("gap_empty", 384'(valid_out), 384'd0);

    // culling
    step(1'b1, va, 1'b1, "cull1"); step(1'b1, va, 1'b1, "cull1"); step(1'b1, vc, 1'b1, "cull1");
    step(1'b1, va, 1'b1, "cull2"); step(1'b1, vb, 1'b1, "cull2"); step(1'b1, vcn, 1'b1, "cull2");
    check_val("cull_valid", 384'(valid_out), 384'd0);
    check_val("cull_drop", 384'(dropped_out), 384'd2);

    // backpressure and overflow
    do_reset("ovf");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, va, 1'b0, "ovf_a"); step(1'b1, vb, 1'b0, "ovf_b"); step(1'b1, vc, 1'b0, "ovf_c");
    end
    check_val("ovf_flag", 384'(overflow_out), 384'd1);
    idle(2, 1'b1, "ovf_drain");
    check_val("ovf_empty", 384'(valid_out), 384'd0);

    // full FIFO with a pop on the completing edge
    do_reset("fullpop");
    for (int k = 0; k < 2; k++) begin
      step(1'b1, va, 1'b0, "fp_a"); step(1'b1, vb, 1'b0, "fp_b"); step(1'b1, vc, 1'b0, "fp_c");
    end
    step(1'b1, vb, 1'b0, "fp_b2"); step(1'b1, vc, 1'b0, "fp_c2"); step(1'b1, va, 1'b1, "fp_a2");
    check_val("fp_ovf", 384'(overflow_out), 384'd0);
    idle(1, 1'b1, "fp_pop1");
    check_val("fp_second", 384'(valid_out), 384'd1);
    check_val("fp_new_tri", triangle_out, {va, vc, vb});
    idle(1, 1'b1, "fp_pop2");
    check_val("fp_empty", 384'(valid_out), 384'd0);

    // reset mid-triangle
    step(1'b1, va, 1'b1, "mid_a"); step(1'b1, vb, 1'b1, "mid_b");
    do_reset("mid");
    step(1'b1, va, 1'b0, "mid_a2"); step(1'b1, vb, 1'b0, "mid_b2"); step(1'b1, vc, 1'b0, "mid_c2");
    check_val("mid_tri", triangle_out, {vc, vb, va});
    idle(1, 1'b1, "mid_pop");

    // saturation of the drop counter
    for (int k = 0; k < DROP_MAX + 3; k++) begin
      step(1'b1, va, 1'b1, "sat"); step(1'b1, va, 1'b1, "sat"); step(1'b1, vb, 1'b1, "sat");
    end
    check_val("sat_drop", 384'(dropped_out), 384'(DROP_MAX));

    // random traffic
    do_reset("rnd");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      else step(1'($urandom_range(0, 3) != 0), pick(), 1'($urandom_range(0, 2) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
